// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by both the TX and RX paths.
package uart_pkg;

  localparam int UART_OVERSAMPLE  = 16;

  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_ODD  = 1;
  localparam int UART_PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    UART_TX_IDLE,
    UART_TX_START,
    UART_TX_DATA,
    UART_TX_PARITY,
    UART_TX_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling enable generator: one-cycle pulse at BAUD_RATE * UART_OVERSAMPLE.
module uart_baud_gen #(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_RATE = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_baud_x16_en
);
  import uart_pkg::*;

  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * UART_OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV == 1 the counter sits at 0 and the enable is permanently high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign o_baud_x16_en = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, none/odd/even parity, 1 or 2 stops)
// with valid/ready input and a registered serial line.
module uart_tx_cfg #(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_RATE = 50_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data_in,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_tx_out
);
  import uart_pkg::*;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < UART_PARITY_NONE || PARITY > UART_PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam logic [3:0] TICK_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != UART_PARITY_NONE);
  localparam bit         ODD_PAR   = (PARITY == UART_PARITY_ODD);

  uart_tx_state_t       state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [3:0]           tick;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 tx_q;
  logic                 done_q;
  logic                 baud_en;
  logic                 bit_end;

  uart_baud_gen #(
    .BAUD_RATE  (BAUD_RATE),
    .CLOCK_RATE (CLOCK_RATE)
  ) u_baud (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_baud_x16_en (baud_en)
  );

  assign bit_end = baud_en && (tick == TICK_LAST);

  // tx_q is loaded with the value of the state being entered, so the line
  // changes on the same edge as the state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= UART_TX_IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tick     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != UART_TX_IDLE && baud_en) tick <= tick + 4'd1;
      case (state)
        UART_TX_IDLE: begin
          tx_q <= 1'b1;
          if (i_valid) begin
            shreg    <= i_data_in;
            par_bit  <= ODD_PAR ? ~(^i_data_in) : ^i_data_in;
            tick     <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b0;
            state    <= UART_TX_START;
          end
        end
        UART_TX_START: if (bit_end) begin
          tx_q  <= shreg[0];
          state <= UART_TX_DATA;
        end
        UART_TX_DATA: if (bit_end) begin
          shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt != LAST_BIT) begin
            tx_q <= shreg[1];
          end else if (HAS_PAR) begin
            tx_q  <= par_bit;
            state <= UART_TX_PARITY;
          end else begin
            tx_q  <= 1'b1;
            state <= UART_TX_STOP;
          end
        end
        UART_TX_PARITY: if (bit_end) begin
          tx_q  <= 1'b1;
          state <= UART_TX_STOP;
        end
        UART_TX_STOP: if (bit_end) begin
          tx_q <= 1'b1;
          if (stop_cnt == STOP_LAST) begin
            done_q <= 1'b1;
            state  <= UART_TX_IDLE;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= UART_TX_IDLE;
        end
      endcase
    end
  end

  assign o_ready  = (state == UART_TX_IDLE);
  assign o_busy   = ~o_ready;
  assign o_done   = done_q;
  assign o_tx_out = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances (8N1, 8E1, 7O2) with one enable per clock.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] vld = '0;
  logic [8:0] din [3];
  logic [2:0] tx, rdy, bsy, dn;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         t1, t2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_cfg #(.BAUD_RATE(100_000), .CLOCK_RATE(1_600_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_data_in(din[0][7:0]), .i_valid(vld[0]),
    .o_ready(rdy[0]), .o_busy(bsy[0]), .o_done(dn[0]), .o_tx_out(tx[0]));

  uart_tx_cfg #(.BAUD_RATE(100_000), .CLOCK_RATE(1_600_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_clk(clk), .i_rst(rst), .i_data_in(din[1][7:0]), .i_valid(vld[1]),
    .o_ready(rdy[1]), .o_busy(bsy[1]), .o_done(dn[1]), .o_tx_out(tx[1]));

  uart_tx_cfg #(.BAUD_RATE(100_000), .CLOCK_RATE(1_600_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .i_clk(clk), .i_rst(rst), .i_data_in(din[2][6:0]), .i_valid(vld[2]),
    .o_ready(rdy[2]), .o_busy(bsy[2]), .o_done(dn[2]), .o_tx_out(tx[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive a word at a negedge; returns at the negedge right after the accepting edge (j=0).
  task automatic start_frame(input int sel, input logic [8:0] data, input bit hold);
    din[sel] = data;
    vld[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) vld[sel] = 1'b0;
  endtask

  // Checks every cycle of a frame against a '0'/'1' string (one char per 16-clock bit),
  // then the done cycle. Optionally pulses a stray valid at inj_j, or stops early at abort_j.
  task automatic check_frame(input int sel, input string exp, input string tag,
                             input int inj_j, input int abort_j);
    int n;
    logic eb;
    n = exp.len();
    for (int j = 0; j < 16 * n; j++) begin
      if (j == abort_j) return;
      eb = (exp[j / 16] == "1");
      chk($sformatf("%s j=%0d tx", tag, j), 32'(tx[sel]), 32'(eb));
      chk($sformatf("%s j=%0d busy", tag, j), 32'(bsy[sel]), 32'd1);
      chk($sformatf("%s j=%0d ready", tag, j), 32'(rdy[sel]), 32'd0);
      chk($sformatf("%s j=%0d done", tag, j), 32'(dn[sel]), 32'd0);
      if (j == inj_j) begin
        din[sel] = 9'h000;
        vld[sel] = 1'b1;
      end else if (j == inj_j + 1) begin
        vld[sel] = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " done_pulse"}, 32'(dn[sel]), 32'd1);
    chk({tag, " done_ready"}, 32'(rdy[sel]), 32'd1);
    chk({tag, " done_busy"}, 32'(bsy[sel]), 32'd0);
    chk({tag, " done_tx"}, 32'(tx[sel]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d tx", i), 32'(tx[i]), 32'd1);
      chk($sformatf("reset%0d ready", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("reset%0d busy", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("reset%0d done", i), 32'(dn[i]), 32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 8N1 0xA5
    start_frame(0, 9'h0A5, 1'b0);
    check_frame(0, "0101001011", "a5_8n1", -10, -1);
    @(negedge clk);
    chk("a5_8n1 done_one_cycle", 32'(dn[0]), 32'd0);
    repeat (2) @(negedge clk);

    // 2: 8E1 0x07, parity 1
    start_frame(1, 9'h007, 1'b0);
    check_frame(1, "01110000011", "07_8e1", -10, -1);
    repeat (3) @(negedge clk);

    // 3: 7O2 0x55, parity 1, two stop bits
    start_frame(2, 9'h055, 1'b0);
    check_frame(2, "01010101111", "55_7o2", -10, -1);
    repeat (3) @(negedge clk);

    // 4: back-to-back with valid held high
    start_frame(0, 9'h03C, 1'b1);
    check_frame(0, "0001111001", "3c_b2b", -10, -1);
    t1 = cyc;
    din[0] = 9'h0C3;
    @(negedge clk);
    vld[0] = 1'b0;
    check_frame(0, "0110000111", "c3_b2b", -10, -1);
    t2 = cyc;
    chk("b2b done_spacing", 32'(t2 - t1), 32'd161);
    repeat (3) @(negedge clk);

    // 5: stray valid during data bits is ignored
    start_frame(0, 9'h0FF, 1'b0);
    check_frame(0, "0111111111", "ff_stray", 40, -1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("ff_stray idle k=%0d tx", k), 32'(tx[0]), 32'd1);
      chk($sformatf("ff_stray idle k=%0d ready", k), 32'(rdy[0]), 32'd1);
    end

    // 6: reset mid-frame, then a clean 0x81 frame
    start_frame(0, 9'h081, 1'b0);
    check_frame(0, "0100000011", "81_abort", -10, 50);
    rst = 1'b0;
    #1;
    chk("midrst tx", 32'(tx[0]), 32'd1);
    chk("midrst busy", 32'(bsy[0]), 32'd0);
    chk("midrst ready", 32'(rdy[0]), 32'd1);
    chk("midrst done", 32'(dn[0]), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst hold tx", 32'(tx[0]), 32'd1);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst k=%0d done", k), 32'(dn[0]), 32'd0);
      chk($sformatf("post_rst k=%0d tx", k), 32'(tx[0]), 32'd1);
    end
    start_frame(0, 9'h081, 1'b0);
    check_frame(0, "0100000011", "81_fresh", -10, -1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter replacing the fixed 8N1 transmitter in the serial path. It supports configurable data width, parity mode and stop-bit count, and uses a valid/ready handshake with input data latched at acceptance. Bit timing comes from the codebase's `uart_baud_gen` x16 enable: each serial bit lasts exactly 16 enables. The block sits between the command/response logic and the board TX pin.

## Interface
Parameters:
- `BAUD_RATE`, 115_200: line rate in bits/s, passed to `uart_baud_gen`.
- `CLOCK_RATE`, 50_000_000: `i_clk` frequency in Hz, passed to `uart_baud_gen`.
- `DATA_BITS`, 8: data bits per frame. Legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal values 1 or 2.
- Illegal parameter values cause an elaboration-time `$error`.

Ports:
- `i_clk`  in  1: the single clock.
- `i_rst`  in  1: reset, asynchronous, active-low.
- `i_data_in`  in  DATA_BITS: word to send. Sampled only at acceptance.
- `i_valid`  in  1: word available.
- `o_ready`  out  1: high in IDLE only.
- `o_busy`  out  1: frame in progress (any state except IDLE).
- `o_done`  out  1: one-cycle pulse when the final stop bit completes.
- `o_tx_out`  out  1: serial line. Idles high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: a rising edge with `i_valid && o_ready`.
  - `i_data_in` is copied into the shift register.
  - Tick counter and bit counter are cleared.
  - State moves to START.
- `i_valid` while busy is ignored. No queuing, and no data is corrupted.
- `o_tx_out` is registered and driven from the state:
  - IDLE: 1.
  - START: 0.
  - DATA: shift register bit 0, sent LSB first.
  - PARITY: parity bit.
  - STOP: 1.
- Bit period: the 4-bit tick counter increments on each x16 enable. When the 16th enable of the current bit arrives, the counter wraps to 0 and the bit ends.
- Transitions at bit end:
  - START → DATA.
  - DATA: shift right and increment the bit counter. After bit `DATA_BITS-1`, go to PARITY if `PARITY != 0`, otherwise to STOP.
  - PARITY → STOP.
  - STOP: the stop counter counts to `STOP_BITS`, then → IDLE with `o_done` pulsed.
- Parity:
  - Computed by XOR of the latched word at acceptance, not from the shifted bits.
  - Even mode: parity bit = XOR of the data bits.
  - Odd mode: parity bit = inverted XOR.
- Frame length: 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits.
- Reset:
  - Reset values: `o_tx_out` = 1, `o_ready` = 1, `o_busy` = 0, `o_done` = 0, state IDLE, all counters 0.
  - Reset asserted mid-frame forces the line high immediately and discards the frame. No `o_done` is produced.

## Timing
- Acceptance edge N: `o_tx_out` falls to 0 and `o_busy` rises to 1 after edge N. `o_ready` drops in the same cycle.
- Each bit is held for exactly 16 x16 enables. With divisor 1 (enable every clock), that is 16 clocks.
- `o_done` is high for exactly one cycle, the first cycle back in IDLE. `o_ready` is 1 in that same cycle.
- Back-to-back frames: with `i_valid` held high, the next word is accepted on the `o_done` cycle. The line is high for exactly 1 clock between the last stop bit and the next start bit.
- `o_busy` = !`o_ready` at all times.

## Structure
- Shared package `uart_pkg` holds:
  - The state enum `uart_tx_state_t`.
  - Parity encodings `UART_PARITY_NONE`/`ODD`/`EVEN`.
  - `UART_OVERSAMPLE = 16`.
  - The same constants are reused by the RX successor.
- One sub-module: `uart_baud_gen`, instantiated with `BAUD_RATE`/`CLOCK_RATE`. Its output `o_baud_x16_en` feeds the tick counter.
- All remaining logic lives in one clocked process plus output assigns.

## Test plan
Bench parameters for all scenarios: `CLOCK_RATE` = 1_600_000, `BAUD_RATE` = 100_000, giving an enable every clock and a 16-clock bit.
1. 8N1, send 0xA5.
   - Line sequence: 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks.
   - `o_done` 160 clocks after acceptance.
2. 8E1, send 0x07.
   - Parity bit 1.
   - 11-bit frame, `o_done` at 176 clocks.
3. 7O2, send 0x55.
   - Data bits 1,0,1,0,1,0,1, then parity 1, then two stop bits.
   - `o_done` at 176 clocks.
4. 8N1, `i_valid` held high with 0x3C then 0xC3.
   - Two frames.
   - Exactly 1 idle-high clock between them.
   - Two `o_done` pulses 161 clocks apart.
5. 8N1, send 0xFF, then pulse `i_valid` with 0x00 during the data bits.
   - Second word ignored.
   - Line shows only the 0xFF frame.
   - `o_ready` = 0 throughout the frame.
6. 8N1, assert `i_rst` low at clock 50 of a frame.
   - `o_tx_out` = 1 immediately, `o_busy` = 0, no `o_done`.
   - After release, a fresh 0x81 frame is sent correctly.
